mux_n_1_stream: RTL and testbench

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes and a registered output stage. It is the successor to the 2:1 combinational word mux. It adds arbitrary channel count and width, a fixed-select or round-robin mode, backpressure, and one pipeline register. It sits between parallel producers (PE output lanes, buffer read ports) and a single consumer stream.

---
 rtl/mux_n_1_stream_pkg.sv | 13 +
 rtl/mux_n_1_stream_if.sv | 30 +++
 rtl/mux_n_1_stream_rr_arbiter.sv | 31 +++
 rtl/mux_n_1_stream.sv | 87 ++++++++
 tb/tb_mux_n_1_stream.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mux_n_1_stream_pkg.sv
// Shared definitions for the N-to-1 streaming multiplexer: mode encodings
// and the channel-id width derivation used by every file of the block.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-id width; a 1-bit id is kept even for degenerate channel counts.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1_stream_if.sv
// Handshake bundle between parallel producers, the multiplexer and the consumer.
// slave = the multiplexer's view, master = the surrounding environment's view.
interface mux_n_1_stream_if
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_IN     = 4
) ();

  localparam int SEL_W = sel_width(NUM_IN);

  logic [NUM_IN-1:0]            in_valid;
  logic [NUM_IN*DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]            in_ready;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]             out_chan;
  logic                         out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

endinterface

// File: rtl/mux_n_1_stream_rr_arbiter.sv
// Rotate-priority encoder: grants the first requesting channel found searching
// upward from ptr+1 and wrapping. Purely combinational; the caller owns ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              gnt_valid,
  output logic [SEL_W-1:0]  gnt_idx
);

  int idx;

  // Walk candidates from farthest to nearest so the nearest requester wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (req[idx[SEL_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_n_1_stream.sv
// N-to-1 streaming multiplexer with fixed-select or round-robin grant and a
// single registered output stage that can refill in the cycle it drains.
module mux_n_1_stream
  import mux_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_IN     = 4,
  localparam int SEL_W      = sel_width(NUM_IN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  mux_n_1_stream_if.slave  bus
);

  logic                  rr_valid_p0;
  logic [SEL_W-1:0]      rr_idx_p0;
  logic                  fix_valid_p0;
  logic                  grant_valid_p0;
  logic [SEL_W-1:0]      grant_idx_p0;
  logic                  load_en_p0;
  logic [NUM_IN-1:0]     in_ready_p0;
  logic                  take_p0;
  logic [DATA_WIDTH-1:0] word_p0;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [SEL_W-1:0]      chan_p1;
  logic [SEL_W-1:0]      rr_ptr;

  // Stage p0: combinational grant, ready and word selection
  rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
    .req       (bus.in_valid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid_p0),
    .gnt_idx   (rr_idx_p0)
  );

  // Out-of-range sel values match no channel and so never grant.
  always_comb begin
    fix_valid_p0 = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i) && bus.in_valid[i]) fix_valid_p0 = 1'b1;
    end
  end

  assign grant_valid_p0 = (mode == MODE_RR) ? rr_valid_p0 : fix_valid_p0;
  assign grant_idx_p0   = (mode == MODE_RR) ? rr_idx_p0   : sel;
  assign load_en_p0     = !vld_p1 || bus.out_ready;

  always_comb begin
    in_ready_p0 = '0;
    word_p0     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx_p0 == SEL_W'(i)) begin
        in_ready_p0[i] = reset_n && load_en_p0 && grant_valid_p0;
        word_p0        = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign take_p0 = |in_ready_p0;

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      rr_ptr  <= SEL_W'(NUM_IN - 1);
    end else if (take_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= word_p0;
      chan_p1 <= grant_idx_p0;
      if (mode == MODE_RR) rr_ptr <= grant_idx_p0;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_chan  = chan_p1;

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Directed bench for mux_n_1_stream: 2-, 3- and 4-channel instances share one
// clock and reset; expected values are hand-computed per step.
module tb_mux_n_1_stream;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mode2, mode3, mode4;
  logic       sel2;
  logic [1:0] sel3, sel4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_n_1_stream_if #(.DATA_WIDTH(8), .NUM_IN(2)) bus2 ();
  mux_n_1_stream_if #(.DATA_WIDTH(8), .NUM_IN(3)) bus3 ();
  mux_n_1_stream_if #(.DATA_WIDTH(8), .NUM_IN(4)) bus4 ();

  mux_n_1_stream #(.DATA_WIDTH(8), .NUM_IN(2)) u2 (
    .clk(clk), .reset_n(reset_n), .mode(mode2), .sel(sel2), .bus(bus2));
  mux_n_1_stream #(.DATA_WIDTH(8), .NUM_IN(3)) u3 (
    .clk(clk), .reset_n(reset_n), .mode(mode3), .sel(sel3), .bus(bus3));
  mux_n_1_stream #(.DATA_WIDTH(8), .NUM_IN(4)) u4 (
    .clk(clk), .reset_n(reset_n), .mode(mode4), .sel(sel4), .bus(bus4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int chan, input logic [7:0] data);
    chk({tag, "_vld"},  bus4.out_valid, 1);
    chk({tag, "_chan"}, bus4.out_chan, chan);
    chk({tag, "_data"}, bus4.out_data, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus2.in_data = {8'h0F, 8'hF0}; bus2.in_valid = 2'b11; bus2.out_ready = 1'b1;
    mode2 = 1'b0; sel2 = 1'b1;
    bus3.in_data = {8'hA2, 8'hA1, 8'hA0}; bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd3;
    bus4.in_data = {8'h13, 8'h12, 8'h11, 8'h10}; bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
    mode4 = 1'b1; sel4 = 2'd0;
    #2;
    chk("rst_vld4",  bus4.out_valid, 0);
    chk("rst_data4", bus4.out_data, 0);
    chk("rst_chan4", bus4.out_chan, 0);
    chk("rst_rdy4",  bus4.in_ready, 0);
    chk("rst_rdy2",  bus2.in_ready, 0);
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("fix_rdy2", bus2.in_ready, 2'b10);
    chk("oor_rdy3", bus3.in_ready, 0);

    // Round-robin over all four channels, with the 2:1 fixed stream alongside
    for (int k = 0; k < 6; k++) begin
      chk("rr_rdy4", bus4.in_ready, 32'd1 << (k % 4));
      tick();
      chk4("rr_out", k % 4, 8'h10 + 8'(k % 4));
      chk("fix_data2", bus2.out_data, 8'h0F);
      chk("fix_chan2", bus2.out_chan, 1);
      chk("oor_vld3",  bus3.out_valid, 0);
    end

    sel3 = 2'd2;
    #1;
    chk("sel2_rdy3", bus3.in_ready, 3'b100);
    tick();
    chk("sel2_chan3", bus3.out_chan, 2);
    chk("sel2_data3", bus3.out_data, 8'hA2);

    // Sparse requests: pointer sits at 1, so grants go 3,1,3 then 0,1
    bus4.in_valid = 4'b1010;
    #1;
    chk("sp_rdy_a", bus4.in_ready, 4'b1000);
    tick(); chk4("sp_a", 3, 8'h13);
    chk("sp_rdy_b", bus4.in_ready, 4'b0010);
    tick(); chk4("sp_b", 1, 8'h11);
    chk("sp_rdy_c", bus4.in_ready, 4'b1000);
    tick(); chk4("sp_c", 3, 8'h13);
    bus4.in_valid = 4'b1011;
    #1;
    chk("sp_rdy_d", bus4.in_ready, 4'b0001);
    tick(); chk4("sp_d", 0, 8'h10);
    chk("sp_rdy_e", bus4.in_ready, 4'b0010);
    tick(); chk4("sp_e", 1, 8'h11);

    // Backpressure: word from channel 1 must hold for five stalled cycles
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rdy", bus4.in_ready, 0);
      tick();
      chk4("bp_hold", 1, 8'h11);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", bus4.in_ready, 4'b1000);
    tick(); chk4("bp_rel_a", 3, 8'h13);
    chk("bp_rel_rdy2", bus4.in_ready, 4'b0001);
    tick(); chk4("bp_rel_b", 0, 8'h10);

    // Fixed mode pointing at an idle channel, then a live one
    mode4 = 1'b0; sel4 = 2'd2;
    #1;
    chk("fx_idle_rdy", bus4.in_ready, 0);
    tick();
    chk("fx_idle_vld",  bus4.out_valid, 0);
    chk("fx_idle_data", bus4.out_data, 8'h10);
    chk("fx_idle_chan", bus4.out_chan, 0);
    sel4 = 2'd3;
    #1;
    chk("fx_rdy", bus4.in_ready, 4'b1000);
    tick(); chk4("fx_out", 3, 8'h13);
    // Pointer must still be 0 after the fixed-mode grant
    mode4 = 1'b1; bus4.in_valid = 4'b1111;
    #1;
    chk("ptr_hold_rdy", bus4.in_ready, 4'b0010);
    tick(); chk4("ptr_hold", 1, 8'h11);

    // Asynchronous reset while stalled with a full register
    bus4.out_ready = 1'b0;
    tick();
    chk("pre_rst_rdy", bus4.in_ready, 0);
    chk4("pre_rst", 1, 8'h11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_vld",  bus4.out_valid, 0);
    chk("arst_data", bus4.out_data, 0);
    chk("arst_chan", bus4.out_chan, 0);
    chk("arst_rdy",  bus4.in_ready, 0);
    tick();
    reset_n = 1'b1;
    bus4.out_ready = 1'b1;
    #1;
    chk("post_rst_rdy", bus4.in_ready, 4'b0001);
    tick(); chk4("post_rst_a", 0, 8'h10);
    chk("post_rst_rdy2", bus4.in_ready, 4'b0010);
    tick(); chk4("post_rst_b", 1, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
